// File: rtl/vend_checkout_ctrl.sv
// Vending checkout: coin debounce, pay/total accumulation, change and IDLE/SHOP/DISPENSE control; optional SEG7_OUT_EN adds 7-segment outputs.
// Press pulse to pay_bcd is 2 cycles and segments lag BCD by 1 cycle; no backpressure, inputs outside IDLE/SHOP are dropped.
`timescale 1ns/1ps
module vend_checkout_ctrl #(
  parameter int                  DIGITS       = 2,
  parameter int                  DEBOUNCE_CYC = 1000000,
  parameter int                  N_COIN       = 2,
  parameter logic [8*N_COIN-1:0] COIN_VALS    = {8'd1, 8'd5},
  parameter logic [31:0]         PRICE_VALS   = {8'd10, 8'd8, 8'd5, 8'd3},
  parameter int                  DISP_CYC     = 50000000
) (
  input  logic                clock,
  input  logic                clr_n,
  input  logic [N_COIN-1:0]   coin_n,
  input  logic [1:0]          item_code,
  input  logic                item_stb,
  input  logic                confirm,
  input  logic                cancel,
  output logic [4*DIGITS-1:0] pay_bcd,
  output logic [4*DIGITS-1:0] total_bcd,
  output logic [4*DIGITS-1:0] change_bcd,
  output logic                insufficient,
  output logic                err_ovf,
  output logic                dispense,
  output logic                refund,
  output logic [1:0]          state
`ifdef SEG7_OUT_EN
  ,
  output logic [7*DIGITS-1:0] seg_pay,
  output logic [7*DIGITS-1:0] seg_total,
  output logic [7*DIGITS-1:0] seg_change
`endif
);

  localparam int MAXV = 10**DIGITS - 1;
  localparam int W    = $clog2(MAXV + 1);
  localparam int BW   = 4*DIGITS;
  localparam int CW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int DW   = $clog2(DISP_CYC + 1);
  localparam int SW   = W + 11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHOP = 2'd1, S_DISP = 2'd2} state_t;

  state_t              st;
  logic [N_COIN-1:0]   sync1, sync2, key_lvl, press;
  logic [CW-1:0]       db_cnt [N_COIN];
  logic [W-1:0]        pay_bin, total_bin, chg_lat, diff;
  logic [DW-1:0]       disp_cnt;
  logic                chg_hold;
  logic [SW-1:0]       coin_sum, pay_sum, tot_sum;
  logic                any_press, pay_ovf, tot_ovf, enough, confirm_go, accum;

  function automatic logic [BW-1:0] bin2bcd(input logic [W-1:0] v);
    logic [BW-1:0] r;
    int            t;
    r = '0;
    t = int'(v);
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // The counter only runs while the synchronised level differs from the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      sync1   <= '1;
      sync2   <= '1;
      key_lvl <= '1;
      press   <= '0;
      for (int i = 0; i < N_COIN; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= coin_n;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < N_COIN; i++) begin
        if (sync2[i] == key_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
          db_cnt[i]  <= '0;
          key_lvl[i] <= sync2[i];
          press[i]   <= key_lvl[i] & ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    coin_sum = '0;
    for (int i = 0; i < N_COIN; i++)
      if (press[i]) coin_sum = coin_sum + SW'(COIN_VALS[8*i +: 8]);
  end

  assign any_press  = |press;
  assign pay_sum    = SW'(pay_bin) + coin_sum;
  assign tot_sum    = SW'(total_bin) + SW'(PRICE_VALS[{item_code, 3'b000} +: 8]);
  assign pay_ovf    = pay_sum > SW'(MAXV);
  assign tot_ovf    = tot_sum > SW'(MAXV);
  assign enough     = pay_bin >= total_bin;
  assign diff       = pay_bin - total_bin;
  assign confirm_go = confirm && (total_bin != '0) && enough;
  assign accum      = (st == S_IDLE) || ((st == S_SHOP) && !cancel && !confirm_go);
  assign state      = st;

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      st        <= S_IDLE;
      pay_bin   <= '0;
      total_bin <= '0;
      chg_lat   <= '0;
      chg_hold  <= 1'b0;
      disp_cnt  <= '0;
      err_ovf   <= 1'b0;
      dispense  <= 1'b0;
      refund    <= 1'b0;
    end else begin
      refund <= 1'b0;
      case (st)
        S_IDLE: begin
          if (any_press || item_stb) begin
            st       <= S_SHOP;
            chg_hold <= 1'b0;
          end
        end
        S_SHOP: begin
          if (cancel) begin
            refund    <= 1'b1;
            pay_bin   <= '0;
            total_bin <= '0;
            err_ovf   <= 1'b0;
            st        <= S_IDLE;
          end else if (confirm_go) begin
            st       <= S_DISP;
            dispense <= 1'b1;
            disp_cnt <= '0;
            chg_hold <= 1'b1;
            chg_lat  <= diff;
          end
        end
        S_DISP: begin
          if (disp_cnt == DW'(DISP_CYC - 1)) begin
            dispense  <= 1'b0;
            pay_bin   <= '0;
            total_bin <= '0;
            err_ovf   <= 1'b0;
            st        <= S_IDLE;
          end else begin
            disp_cnt <= disp_cnt + DW'(1);
          end
        end
        default: st <= S_IDLE;
      endcase
      // A press and a strobe in the same cycle are both applied; each saturates on its own.
      if (accum && any_press) begin
        if (pay_ovf) err_ovf <= 1'b1;
        else         pay_bin <= pay_sum[W-1:0];
      end
      if (accum && item_stb) begin
        if (tot_ovf) err_ovf   <= 1'b1;
        else         total_bin <= tot_sum[W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      pay_bcd      <= '0;
      total_bcd    <= '0;
      change_bcd   <= '0;
      insufficient <= 1'b0;
    end else begin
      pay_bcd   <= bin2bcd(pay_bin);
      total_bcd <= bin2bcd(total_bin);
      if (chg_hold) begin
        change_bcd   <= bin2bcd(chg_lat);
        insufficient <= 1'b0;
      end else begin
        change_bcd   <= enough ? bin2bcd(diff) : '1;
        insufficient <= !enough;
      end
    end
  end

`ifdef SEG7_OUT_EN
  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'h0:    return 7'b100_0000;
      4'h1:    return 7'b111_1001;
      4'h2:    return 7'b010_0100;
      4'h3:    return 7'b011_0000;
      4'h4:    return 7'b001_1001;
      4'h5:    return 7'b001_0010;
      4'h6:    return 7'b000_0010;
      4'h7:    return 7'b111_1000;
      4'h8:    return 7'b000_0000;
      4'h9:    return 7'b001_0000;
      4'hF:    return 7'b000_1110;
      default: return 7'b011_1111;
    endcase
  endfunction

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      seg_pay    <= {DIGITS{7'b100_0000}};
      seg_total  <= {DIGITS{7'b100_0000}};
      seg_change <= {DIGITS{7'b100_0000}};
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        seg_pay[7*d +: 7]    <= seg7(pay_bcd[4*d +: 4]);
        seg_total[7*d +: 7]  <= seg7(total_bcd[4*d +: 4]);
        seg_change[7*d +: 7] <= seg7(change_bcd[4*d +: 4]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vend_checkout_ctrl.sv
// Bench for vend_checkout_ctrl: directed scenarios followed by random coin/item/confirm/cancel traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_vend_checkout_ctrl;
  localparam int DEB  = 8;
  localparam int DISP = 40;

  logic       clock = 1'b0;
  logic       clr_n;
  logic [1:0] coin_n;
  logic [1:0] item_code;
  logic       item_stb, confirm, cancel;
  logic [7:0] pay_bcd, total_bcd, change_bcd;
  logic       insufficient, err_ovf, dispense, refund;
  logic [1:0] state;

  always #5 clock = ~clock;

  vend_checkout_ctrl #(
    .DIGITS(2), .DEBOUNCE_CYC(DEB), .N_COIN(2),
    .COIN_VALS(16'h0501), .PRICE_VALS(32'h0A080503), .DISP_CYC(DISP)
  ) dut (
    .clock(clock), .clr_n(clr_n), .coin_n(coin_n), .item_code(item_code),
    .item_stb(item_stb), .confirm(confirm), .cancel(cancel),
    .pay_bcd(pay_bcd), .total_bcd(total_bcd), .change_bcd(change_bcd),
    .insufficient(insufficient), .err_ovf(err_ovf), .dispense(dispense),
    .refund(refund), .state(state)
  );

  int coin_v[2]  = '{1, 5};
  int price_v[4] = '{3, 5, 8, 10};

  // Reference model: amounts as plain integers, state 0/1/2 = idle/shopping/dispensing.
  int m_pay, m_total, m_state, m_lat;
  bit m_ovf, m_hold;
  int n_chk = 0;
  int n_err = 0;
  int lat;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic void m_reset();
    m_pay = 0; m_total = 0; m_state = 0; m_lat = 0; m_ovf = 0; m_hold = 0;
  endfunction

  function automatic void m_event(input int sum, input bit has_press, input bit stb, input int code);
    if (m_state == 2) return;
    if (m_state == 0) begin
      if (!(has_press || stb)) return;
      m_state = 1;
      m_hold  = 0;
    end
    if (has_press) begin
      if (m_pay + sum > 99) m_ovf = 1; else m_pay = m_pay + sum;
    end
    if (stb) begin
      if (m_total + price_v[code] > 99) m_ovf = 1; else m_total = m_total + price_v[code];
    end
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] ec;
    bit         ei;
    if (m_hold) begin ec = to_bcd(m_lat); ei = 0; end
    else if (m_pay >= m_total) begin ec = to_bcd(m_pay - m_total); ei = 0; end
    else begin ec = 8'hFF; ei = 1; end
    check_val({tag, ".pay"},      pay_bcd,      to_bcd(m_pay));
    check_val({tag, ".total"},    total_bcd,    to_bcd(m_total));
    check_val({tag, ".change"},   change_bcd,   ec);
    check_val({tag, ".insuff"},   insufficient, ei);
    check_val({tag, ".ovf"},      err_ovf,      m_ovf);
    check_val({tag, ".state"},    state,        m_state);
    check_val({tag, ".dispense"}, dispense,     (m_state == 2));
    check_val({tag, ".refund"},   refund,       0);
  endtask

  task automatic press_coins(input logic [1:0] mask);
    int sum;
    sum = 0;
    for (int i = 0; i < 2; i++) if (mask[i]) sum = sum + coin_v[i];
    @(negedge clock); coin_n = ~mask;
    repeat (DEB + 6) @(negedge clock);
    coin_n = 2'b11;
    repeat (DEB + 6) @(negedge clock);
    m_event(sum, 1, 0, 0);
  endtask

  task automatic strobe_item(input logic [1:0] code);
    @(negedge clock); item_code = code; item_stb = 1'b1;
    @(negedge clock); item_stb = 1'b0;
    repeat (3) @(negedge clock);
    m_event(0, 0, 1, int'(code));
  endtask

  task automatic do_cancel(input bit with_confirm);
    int rc, exp_rc;
    exp_rc = (m_state == 1) ? 1 : 0;
    @(negedge clock); cancel = 1'b1; confirm = with_confirm;
    @(negedge clock); cancel = 1'b0; confirm = 1'b0;
    rc = 0;
    for (int k = 0; k < 4; k++) begin
      if (refund) rc++;
      @(negedge clock);
    end
    check_val("refund_cnt", rc, exp_rc);
    if (exp_rc == 1) begin m_pay = 0; m_total = 0; m_ovf = 0; m_state = 0; end
    repeat (2) @(negedge clock);
  endtask

  task automatic do_confirm(input bit press_during, input logic [1:0] mask);
    bit go;
    int cnt, k;
    go = (m_state == 1) && (m_total > 0) && (m_pay >= m_total);
    @(negedge clock); confirm = 1'b1;
    @(negedge clock); confirm = 1'b0;
    if (go) begin
      m_lat = m_pay - m_total; m_hold = 1; m_state = 2;
      check_all("disp_on");
      if (press_during) coin_n = ~mask;
      cnt = 0; k = 0;
      while (dispense && k < 3*DISP) begin
        cnt++; k++;
        if (k == DEB + 6) coin_n = 2'b11;
        @(negedge clock);
      end
      coin_n = 2'b11;
      check_val("disp_len", cnt, DISP);
      m_state = 0; m_pay = 0; m_total = 0; m_ovf = 0;
      repeat (DEB + 6) @(negedge clock);
    end else begin
      repeat (3) @(negedge clock);
    end
  endtask

  initial begin
    int  n, sel;
    bit  found;
    clr_n = 1'b0; coin_n = 2'b11; item_code = 2'd0;
    item_stb = 1'b0; confirm = 1'b0; cancel = 1'b0;
    m_reset();
    repeat (3) @(negedge clock);
    check_all("reset");
    clr_n = 1'b1;
    repeat (3) @(negedge clock);

    // Debounce: two short glitches, then a real hold on coin0.
    for (int g = 0; g < 2; g++) begin
      coin_n = 2'b10; repeat (3) @(negedge clock);
      coin_n = 2'b11; repeat (3) @(negedge clock);
    end
    check_all("glitch");
    coin_n = 2'b10;
    n = 0; found = 0;
    while (!found && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (pay_bcd != 8'h00) found = 1;
    end
    check_val("deb_latency_ok", (found && n >= DEB + 3 && n <= DEB + 6), 1);
    lat = (found && n >= 4) ? n : DEB + 4;
    @(negedge clock);
    repeat (DEB) @(negedge clock);
    coin_n = 2'b11;
    repeat (DEB + 6) @(negedge clock);
    m_event(1, 1, 0, 0);
    check_all("debounce");

    // Accumulate and borrow.
    do_cancel(0);
    press_coins(2'b10); press_coins(2'b10); press_coins(2'b01);
    strobe_item(2'd0); strobe_item(2'd1);
    check_all("accum");

    // Insufficient confirm is ignored.
    do_cancel(0);
    press_coins(2'b10);
    strobe_item(2'd0); strobe_item(2'd1);
    do_confirm(0, 2'b00);
    check_all("insuff");

    // Exact payment dispenses; a coin during dispense is dropped.
    do_cancel(0);
    press_coins(2'b10); press_coins(2'b10);
    strobe_item(2'd3);
    do_confirm(1, 2'b10);
    check_all("dispensed");

    // Overflow, then cancel+confirm together.
    do_cancel(0);
    for (int i = 0; i < 19; i++) press_coins(2'b10);
    check_all("pay95");
    press_coins(2'b10);
    check_all("overflow");
    do_cancel(1);
    check_all("cancel");

    // Both coins and an item strobe land in the same cycle from idle.
    @(negedge clock); coin_n = 2'b00;
    repeat (lat - 2) @(posedge clock);
    @(negedge clock); item_code = 2'd3; item_stb = 1'b1;
    @(negedge clock); item_stb = 1'b0;
    repeat (DEB + 6) @(negedge clock);
    coin_n = 2'b11;
    repeat (DEB + 6) @(negedge clock);
    m_event(6, 1, 1, 3);
    check_all("simul");

    for (int op = 0; op < 40; op++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      press_coins(2'($urandom_range(1, 3)));
      else if (sel < 7) strobe_item(2'($urandom_range(0, 3)));
      else if (sel < 9) do_confirm($urandom_range(0, 1) == 1, 2'($urandom_range(1, 3)));
      else              do_cancel(1'($urandom_range(0, 1)));
      check_all($sformatf("rnd%0d", op));
    end

    // Asynchronous reset in the middle of a dispense.
    do_cancel(0);
    press_coins(2'b10);
    strobe_item(2'd0);
    @(negedge clock); confirm = 1'b1;
    @(negedge clock); confirm = 1'b0;
    repeat (5) @(negedge clock);
    check_val("rst_pre_dispense", dispense, 1);
    #2 clr_n = 1'b0;
    #1 check_val("rst_async_dispense", dispense, 0);
    m_reset();
    @(negedge clock);
    check_all("rst_mid");
    clr_n = 1'b1;
    repeat (3) @(negedge clock);
    check_all("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
